// File: rtl/gpio_pattern_gen.sv
// WIDTH-bit GPIO pattern generator: prescaled rotate-left/right, bounce and binary count, with parallel load.
// Build option: define GPIO_PAT_SINGLE_STEP_EN to add step_req (one step per request while enable = 0).
module gpio_pattern_gen #(
    parameter int               WIDTH         = 32,
    parameter int               PRESCALE_W    = 24,
    parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b1}}, 1'b0}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_pattern,
    output logic [WIDTH-1:0]      pattern,
    output logic                  tick,
    output logic                  wrap
`ifdef GPIO_PAT_SINGLE_STEP_EN
    ,
    input  logic                  step_req
`endif
);
    localparam int               POS_W    = $clog2(WIDTH);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [1:0] MODE_ROL    = 2'd0;
    localparam logic [1:0] MODE_ROR    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

    logic [WIDTH-1:0]      pattern_reg, pattern_next, pattern_step;
    logic [WIDTH-1:0]      rol_val, ror_val;
    logic [PRESCALE_W-1:0] cnt_reg, cnt_next;
    logic                  tick_reg, tick_next;
    logic [POS_W-1:0]      pos_reg, pos_next, pos_eff, pos_step, pos_inc;
    dir_t                  dir_reg, dir_next, dir_eff, dir_step;
    logic [1:0]            mode_q_reg;
    logic                  mode_change, manual_step, step, wrap_cond;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rol_val[gi] = pattern_reg[(gi + WIDTH - 1) % WIDTH];
            assign ror_val[gi] = pattern_reg[(gi + 1) % WIDTH];
        end
    endgenerate

`ifdef GPIO_PAT_SINGLE_STEP_EN
    assign manual_step = ~enable & step_req;
`else
    assign manual_step = 1'b0;
`endif

    // tick_reg marks the cycle whose closing edge commits a step; load or reset cancels it.
    assign step    = ~rst & ~load & ((enable & tick_reg) | manual_step);
    assign tick    = step;
    assign wrap    = step & wrap_cond;
    assign pattern = pattern_reg;

    always_comb begin
        cnt_next  = cnt_reg;
        tick_next = 1'b0;
        if (load) begin
            cnt_next = '0;
        end else if (enable) begin
            if (cnt_reg >= period) begin
                cnt_next  = '0;
                tick_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // A mode change restarts the walk from pos 0 going left, even within the stepping cycle.
    always_comb begin
        mode_change  = (mode != mode_q_reg);
        pos_eff      = mode_change ? '0 : pos_reg;
        dir_eff      = mode_change ? DIR_LEFT : dir_reg;
        pos_inc      = (pos_eff == POS_LAST) ? '0 : pos_eff + 1'b1;
        pattern_step = pattern_reg;
        pos_step     = pos_eff;
        dir_step     = dir_eff;
        wrap_cond    = 1'b0;
        case (mode)
            MODE_ROL: begin
                pattern_step = rol_val;
                pos_step     = pos_inc;
                wrap_cond    = (pos_eff == POS_LAST);
            end
            MODE_ROR: begin
                pattern_step = ror_val;
                pos_step     = pos_inc;
                wrap_cond    = (pos_eff == POS_LAST);
            end
            MODE_BOUNCE: begin
                if (dir_eff == DIR_LEFT) begin
                    pattern_step = rol_val;
                    pos_step     = pos_inc;
                    if (pos_inc == POS_LAST) begin
                        dir_step  = DIR_RIGHT;
                        wrap_cond = 1'b1;
                    end
                end else begin
                    pattern_step = ror_val;
                    pos_step     = pos_eff - 1'b1;
                    if (pos_eff == POS_ONE) begin
                        dir_step  = DIR_LEFT;
                        wrap_cond = 1'b1;
                    end
                end
            end
            MODE_COUNT: begin
                pattern_step = pattern_reg + 1'b1;
                wrap_cond    = &pattern_reg;
            end
            default: ;
        endcase
    end

    always_comb begin
        pattern_next = pattern_reg;
        pos_next     = pos_eff;
        dir_next     = dir_eff;
        if (load) begin
            pattern_next = load_pattern;
            pos_next     = '0;
            dir_next     = DIR_LEFT;
        end else if (step) begin
            pattern_next = pattern_step;
            pos_next     = pos_step;
            dir_next     = dir_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_reg <= RESET_PATTERN;
            cnt_reg     <= '0;
            tick_reg    <= 1'b0;
            pos_reg     <= '0;
            dir_reg     <= DIR_LEFT;
            mode_q_reg  <= mode;
        end else begin
            pattern_reg <= pattern_next;
            cnt_reg     <= cnt_next;
            tick_reg    <= tick_next;
            pos_reg     <= pos_next;
            dir_reg     <= dir_next;
            mode_q_reg  <= mode;
        end
    end
endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Scoreboard bench for gpio_pattern_gen: a 32-bit and an 8-bit instance share one clock.
// Expected step results are queued as stimulus is set up and popped on each observed tick.
`timescale 1ns/1ps
module tb_gpio_pattern_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    logic        a_rst, a_enable, a_load, a_tick, a_wrap;
    logic [1:0]  a_mode;
    logic [23:0] a_period;
    logic [31:0] a_load_pattern, a_pattern;
    logic        b_rst, b_enable, b_load, b_tick, b_wrap;
    logic [1:0]  b_mode;
    logic [7:0]  b_period;
    logic [7:0]  b_load_pattern, b_pattern;
`ifdef GPIO_PAT_SINGLE_STEP_EN
    logic        a_step_req, b_step_req;
`endif

    gpio_pattern_gen #(.WIDTH(32), .PRESCALE_W(24), .RESET_PATTERN(32'hFFFF_FFFE)) dut_a (
        .clk(clk), .rst(a_rst), .enable(a_enable), .mode(a_mode), .period(a_period),
        .load(a_load), .load_pattern(a_load_pattern), .pattern(a_pattern), .tick(a_tick), .wrap(a_wrap)
`ifdef GPIO_PAT_SINGLE_STEP_EN
        , .step_req(a_step_req)
`endif
    );

    gpio_pattern_gen #(.WIDTH(8), .PRESCALE_W(8), .RESET_PATTERN(8'hFE)) dut_b (
        .clk(clk), .rst(b_rst), .enable(b_enable), .mode(b_mode), .period(b_period),
        .load(b_load), .load_pattern(b_load_pattern), .pattern(b_pattern), .tick(b_tick), .wrap(b_wrap)
`ifdef GPIO_PAT_SINGLE_STEP_EN
        , .step_req(b_step_req)
`endif
    );

    typedef struct packed {
        logic [31:0] pat;
        logic        wr;
    } exp_t;
    exp_t a_q[$];
    exp_t b_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", tag, obs, cyc);
        end
    endtask

    task automatic push_a(input logic [31:0] p, input logic w);
        a_q.push_back({p, w});
    endtask

    task automatic push_b(input logic [31:0] p, input logic w);
        b_q.push_back({p, w});
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int k, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) r[(i + k) % w] = x[i];
        return r;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Runs one instance until n ticks are seen, checking first-tick latency and tick spacing.
    task automatic run_steps(input string tag, input bit sel_b, input int n, input int first_lat, input int iv);
        int got = 0;
        int last = 0;
        int start;
        int budget;
        start  = cyc;
        budget = n * (iv + 2) + 20;
        if (sel_b) b_enable = 1'b1; else a_enable = 1'b1;
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (sel_b ? b_tick : a_tick) begin
                if (got == 0 && first_lat >= 0) check_eq({tag, "_first_tick"}, cyc - start, first_lat);
                if (got > 0) check_eq({tag, "_tick_spacing"}, cyc - last, iv);
                last = cyc;
                got++;
            end
        end
        check_eq({tag, "_ticks_seen"}, got, n);
        @(posedge clk);
        #1;
        if (sel_b) b_enable = 1'b0; else a_enable = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard: wrap is checked with the tick, the stepped pattern one cycle later.
    initial begin : monitor
        exp_t e;
        logic a_pend = 1'b0;
        logic b_pend = 1'b0;
        logic [31:0] a_pend_pat = '0;
        logic [31:0] b_pend_pat = '0;
        forever begin
            @(negedge clk);
            if (a_pend) begin
                check_eq("a_pattern", a_pattern, a_pend_pat);
                a_pend = 1'b0;
            end
            if (b_pend) begin
                check_eq("b_pattern", 32'(b_pattern), b_pend_pat);
                b_pend = 1'b0;
            end
            if (a_tick) begin
                if (a_q.size() == 0) begin
                    check_eq("a_spurious_tick", 32'(a_tick), 0);
                end else begin
                    e = a_q.pop_front();
                    check_eq("a_wrap", 32'(a_wrap), 32'(e.wr));
                    a_pend = 1'b1;
                    a_pend_pat = e.pat;
                end
            end else if (a_wrap) begin
                check_eq("a_wrap_without_tick", 32'(a_wrap), 0);
            end
            if (b_tick) begin
                if (b_q.size() == 0) begin
                    check_eq("b_spurious_tick", 32'(b_tick), 0);
                end else begin
                    e = b_q.pop_front();
                    check_eq("b_wrap", 32'(b_wrap), 32'(e.wr));
                    b_pend = 1'b1;
                    b_pend_pat = e.pat;
                end
            end else if (b_wrap) begin
                check_eq("b_wrap_without_tick", 32'(b_wrap), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0;
        int t1;
        int tl;
        int rel;
        a_rst = 1'b1; a_enable = 1'b0; a_mode = 2'd0; a_period = 24'd0; a_load = 1'b0; a_load_pattern = '0;
        b_rst = 1'b1; b_enable = 1'b0; b_mode = 2'd0; b_period = 8'd0;  b_load = 1'b0; b_load_pattern = '0;
`ifdef GPIO_PAT_SINGLE_STEP_EN
        a_step_req = 1'b0; b_step_req = 1'b0;
`endif
        cycles(2);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check_eq("a_reset_pattern", a_pattern, 32'hFFFF_FFFE);
        check_eq("a_reset_tick", 32'(a_tick), 0);
        check_eq("a_reset_wrap", 32'(a_wrap), 0);
        check_eq("b_reset_pattern", 32'(b_pattern), 32'h0000_00FE);

        // Disabled: 100 cycles without change, then a load is still taken.
        cycles(1);
        a_period = 24'd0;
        a_load_pattern = 32'hDEAD_BEEF;
        cycles(100);
        @(negedge clk);
        check_eq("a_hold_disabled", a_pattern, 32'hFFFF_FFFE);
        cycles(1);
        a_load = 1'b1; a_load_pattern = 32'h1234_5678;
        cycles(1);
        a_load = 1'b0;
        @(negedge clk);
        check_eq("a_load_disabled", a_pattern, 32'h1234_5678);
        cycles(1);
        a_load = 1'b1; a_load_pattern = 32'hFFFF_FFFE;
        cycles(1);
        a_load = 1'b0;

        // Rotate left, period 3: tick every 4 clocks, wrap on the 32nd step.
        a_period = 24'd3;
        for (int k = 1; k <= 33; k++) push_a(rotl(32'hFFFF_FFFE, k, 32), (k % 32) == 0);
        run_steps("a_rol", 1'b0, 33, 4, 4);
        check_eq("a_rol_queue_left", a_q.size(), 0);

        // Load in the cycle where cnt == period: no tick, prescaler restarts.
        a_load = 1'b1; a_load_pattern = 32'h0000_00F0;
        cycles(1);
        a_load = 1'b0;
        push_a(32'h0000_01E0, 1'b0);
        a_enable = 1'b1;
        t0 = -1;
        for (int i = 0; i < 20 && t0 < 0; i++) begin
            @(negedge clk);
            if (a_tick) t0 = cyc;
        end
        check_eq("a_pre_load_tick_seen", 32'(t0 >= 0), 1);
        cycles(3);
        a_load = 1'b1; a_load_pattern = 32'hA5A5_0001;
        tl = cyc;
        @(negedge clk);
        check_eq("a_load_cycle_tick", 32'(a_tick), 0);
        cycles(1);
        a_load = 1'b0;
        @(negedge clk);
        check_eq("a_load_over_step", a_pattern, 32'hA5A5_0001);
        push_a(32'h4B4A_0003, 1'b0);
        t1 = -1;
        for (int i = 0; i < 20 && t1 < 0; i++) begin
            @(negedge clk);
            if (a_tick) t1 = cyc;
        end
        check_eq("a_tick_after_load", t1 - tl, 5);
        cycles(1);
        a_enable = 1'b0;

        // Count mode across all-ones.
        a_mode = 2'd3; a_period = 24'd0;
        a_load = 1'b1; a_load_pattern = 32'hFFFF_FFFF;
        cycles(1);
        a_load = 1'b0;
        push_a(32'h0000_0000, 1'b1);
        push_a(32'h0000_0001, 1'b0);
        push_a(32'h0000_0002, 1'b0);
        run_steps("a_count", 1'b0, 3, 1, 1);
        check_eq("a_count_queue_left", a_q.size(), 0);

        // Rotate right, then a one-cycle reset in the middle of the run.
        a_mode = 2'd1; a_period = 24'd2;
        a_load = 1'b1; a_load_pattern = 32'h8000_0000;
        cycles(1);
        a_load = 1'b0;
        push_a(32'h4000_0000, 1'b0);
        push_a(32'h2000_0000, 1'b0);
        run_steps("a_ror", 1'b0, 2, 3, 3);
        a_enable = 1'b1; a_rst = 1'b1;
        cycles(1);
        a_rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        check_eq("a_rst_mid_pattern", a_pattern, 32'hFFFF_FFFE);
        check_eq("a_rst_mid_tick", 32'(a_tick), 0);
        push_a(32'h7FFF_FFFF, 1'b0);
        run_steps("a_after_rst", 1'b0, 1, 3 - (cyc - rel), 3);
        check_eq("a_ror_queue_left", a_q.size(), 0);

`ifdef GPIO_PAT_SINGLE_STEP_EN
        a_mode = 2'd0;
        a_load = 1'b1; a_load_pattern = 32'h0000_0001;
        cycles(1);
        a_load = 1'b0;
        push_a(32'h0000_0002, 1'b0);
        a_step_req = 1'b1;
        cycles(1);
        a_step_req = 1'b0;
        cycles(4);
        check_eq("a_single_step_queue_left", a_q.size(), 0);
        @(negedge clk);
        check_eq("a_single_step_hold", a_pattern, 32'h0000_0002);
        cycles(1);
`endif

        // 8-bit bounce: wrap on the steps producing 80 and 01.
        b_mode = 2'd2; b_period = 8'd0;
        b_load = 1'b1; b_load_pattern = 8'h01;
        cycles(1);
        b_load = 1'b0;
        for (int k = 1; k <= 7; k++) push_b(32'd1 << k, k == 7);
        for (int k = 6; k >= 0; k--) push_b(32'd1 << k, k == 0);
        push_b(32'h0000_0002, 1'b0);
        run_steps("b_bounce", 1'b1, 15, 1, 1);
        check_eq("b_bounce_queue_left", b_q.size(), 0);

        // Mode change restarts position at 0: the 8th left rotate wraps.
        b_mode = 2'd0;
        cycles(1);
        for (int k = 1; k <= 8; k++) push_b(rotl(32'h0000_0002, k, 8), k == 8);
        run_steps("b_rol", 1'b1, 8, 1, 1);
        check_eq("b_rol_queue_left", b_q.size(), 0);

        cycles(3);
        check_eq("a_final_queue_left", a_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
